// File: rtl/eth_rx_frame_checker.sv
// eth_rx_frame_checker
//
// Receive-side traffic checker for the MAC RX AXI-Stream output. Each frame
// is checked for an incrementing-byte payload (lane i of the stream carries
// seed + position), legal byte enables, legal length and the MAC error flag.
// A per-frame verdict is reported and saturating good/bad counters are kept.
//
// Ports
//   i_rx_clk       RX clock, all logic on the rising edge
//   i_rx_reset_n   asynchronous active-low reset
//   s_axis_*       AXI-Stream input without tready (every valid beat accepted)
//                  tdata lane 0 is the first byte on the wire; tuser is the
//                  MAC frame error and only matters on the tlast beat
//   i_clear        synchronous clear of the good/bad counters
//   o_frame_done   one-cycle pulse per completed frame
//   o_frame_ok     verdict of the last completed frame (held)
//   o_err_flags    {tuser, long, short, keep, pattern} of the last frame (held)
//   o_frame_len    byte length of the last frame (held)
//   o_good_cnt     frames finished with no error flag
//   o_bad_cnt      frames finished with at least one error flag
module eth_rx_frame_checker #(
  parameter int N_SYMBOLS = 8,
  parameter int W_SYMBOL  = 8,
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1514,
  parameter int W_CNT     = 32
) (
  input  logic                          i_rx_clk,
  input  logic                          i_rx_reset_n,
  input  logic                          s_axis_tvalid,
  input  logic [N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
  input  logic [N_SYMBOLS-1:0]          s_axis_tkeep,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tuser,
  input  logic                          i_clear,
  output logic                          o_frame_done,
  output logic                          o_frame_ok,
  output logic [4:0]                    o_err_flags,
  output logic [15:0]                   o_frame_len,
  output logic [W_CNT-1:0]              o_good_cnt,
  output logic [W_CNT-1:0]              o_bad_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  localparam logic [N_SYMBOLS-1:0] KEEP_ALL = '1;

  state_t              state_q, state_d;
  logic [W_SYMBOL-1:0] base_q, base_d;
  logic [15:0]         len_q, len_d;
  logic                pat_err_q, pat_err_d;
  logic                keep_err_q, keep_err_d;

  // Finished-frame stage between the tlast beat and the reported verdict.
  logic                pend_q, pend_d;
  logic [4:0]          pend_flags_q, pend_flags_d;
  logic [15:0]         pend_len_q, pend_len_d;
  logic                pend_cnt_q, pend_cnt_d;

  logic                done_q, done_d;
  logic                ok_q, ok_d;
  logic [4:0]          flags_q, flags_d;
  logic [15:0]         flen_q, flen_d;
  logic [W_CNT-1:0]    good_q, good_d;
  logic [W_CNT-1:0]    bad_q, bad_d;

  logic [W_SYMBOL-1:0]  exp_base;
  logic                 beat_pat_err;
  logic                 beat_keep_err;
  logic [N_SYMBOLS-1:0] keep_plus1;
  logic [16:0]          beat_pop;
  logic [16:0]          len_wide;
  logic [15:0]          len_sum;
  logic [4:0]           fin_flags;

  // Evaluation of the beat currently on the bus. On a first beat the
  // expected lane-0 byte is the received byte itself, so the seed lane
  // always matches.
  always_comb begin
    exp_base     = (state_q == ST_IDLE) ? s_axis_tdata[W_SYMBOL-1:0] : base_q;
    beat_pat_err = 1'b0;
    beat_pop     = '0;
    for (int i = 0; i < N_SYMBOLS; i++) begin
      if (s_axis_tkeep[i]) begin
        beat_pop = beat_pop + 17'd1;
        if (s_axis_tdata[i*W_SYMBOL +: W_SYMBOL] != exp_base + W_SYMBOL'(i)) begin
          beat_pat_err = 1'b1;
        end
      end
    end

    // A contiguous-from-lane-0 mask has no set bit in common with mask+1.
    keep_plus1 = s_axis_tkeep + N_SYMBOLS'(1);
    if (s_axis_tlast) begin
      beat_keep_err = (s_axis_tkeep == '0) || ((s_axis_tkeep & keep_plus1) != '0);
    end else begin
      beat_keep_err = (s_axis_tkeep != KEEP_ALL);
    end

    len_wide = {1'b0, len_q} + beat_pop;
    len_sum  = len_wide[16] ? 16'hFFFF : len_wide[15:0];

    fin_flags = {s_axis_tuser,
                 (len_sum > 16'(MAX_LEN)),
                 (len_sum < 16'(MIN_LEN)),
                 keep_err_q | beat_keep_err,
                 pat_err_q  | beat_pat_err};
  end

  // Next-state: frame tracking, finished-frame stage and reported outputs.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    pat_err_d    = pat_err_q;
    keep_err_d   = keep_err_q;
    pend_d       = 1'b0;
    pend_flags_d = pend_flags_q;
    pend_len_d   = pend_len_q;
    pend_cnt_d   = pend_cnt_q;
    done_d       = pend_q;
    ok_d         = ok_q;
    flags_d      = flags_q;
    flen_d       = flen_q;
    good_d       = good_q;
    bad_d        = bad_q;

    if (s_axis_tvalid) begin
      if (s_axis_tlast) begin
        state_d      = ST_IDLE;
        base_d       = '0;
        len_d        = '0;
        pat_err_d    = 1'b0;
        keep_err_d   = 1'b0;
        pend_d       = 1'b1;
        pend_flags_d = fin_flags;
        pend_len_d   = len_sum;
        // A clear on the tlast cycle means this frame is never counted.
        pend_cnt_d   = ~i_clear;
      end else begin
        state_d    = ST_BODY;
        base_d     = exp_base + W_SYMBOL'(N_SYMBOLS);
        len_d      = len_sum;
        pat_err_d  = pat_err_q | beat_pat_err;
        keep_err_d = keep_err_q | beat_keep_err;
      end
    end

    if (pend_q) begin
      ok_d    = (pend_flags_q == 5'd0);
      flags_d = pend_flags_q;
      flen_d  = pend_len_q;
      if (pend_cnt_q) begin
        if (pend_flags_q == 5'd0) begin
          if (good_q != '1) good_d = good_q + W_CNT'(1);
        end else begin
          if (bad_q != '1) bad_d = bad_q + W_CNT'(1);
        end
      end
    end

    if (i_clear) begin
      good_d = '0;
      bad_d  = '0;
    end
  end

  always_ff @(posedge i_rx_clk or negedge i_rx_reset_n) begin
    if (!i_rx_reset_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      pat_err_q    <= 1'b0;
      keep_err_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_flags_q <= '0;
      pend_len_q   <= '0;
      pend_cnt_q   <= 1'b0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      flags_q      <= '0;
      flen_q       <= '0;
      good_q       <= '0;
      bad_q        <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      pat_err_q    <= pat_err_d;
      keep_err_q   <= keep_err_d;
      pend_q       <= pend_d;
      pend_flags_q <= pend_flags_d;
      pend_len_q   <= pend_len_d;
      pend_cnt_q   <= pend_cnt_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
      flags_q      <= flags_d;
      flen_q       <= flen_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
    end
  end

  assign o_frame_done = done_q;
  assign o_frame_ok   = ok_q;
  assign o_err_flags  = flags_q;
  assign o_frame_len  = flen_q;
  assign o_good_cnt   = good_q;
  assign o_bad_cnt    = bad_q;

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// Testbench for eth_rx_frame_checker. Two instances share one stimulus
// stream: the default build and a W_CNT=4 build for counter saturation.
// Expected verdicts come from a frame-level model: byte k of a frame
// (k = beat*8 + lane) must equal first byte + k.
module tb_eth_rx_frame_checker;

  logic        clk = 1'b0;
  logic        rstN;
  logic        sValid, sLast, sUser, clr;
  logic [63:0] sData;
  logic [7:0]  sKeep;

  logic        frameDone, frameOk;
  logic [4:0]  errFlags;
  logic [15:0] frameLen;
  logic [31:0] goodCnt, badCnt;
  logic        frameDone4, frameOk4;
  logic [4:0]  errFlags4;
  logic [15:0] frameLen4;
  logic [3:0]  goodCnt4, badCnt4;

  always #5 clk = ~clk;

  eth_rx_frame_checker dut (
    .i_rx_clk(clk), .i_rx_reset_n(rstN),
    .s_axis_tvalid(sValid), .s_axis_tdata(sData), .s_axis_tkeep(sKeep),
    .s_axis_tlast(sLast), .s_axis_tuser(sUser), .i_clear(clr),
    .o_frame_done(frameDone), .o_frame_ok(frameOk), .o_err_flags(errFlags),
    .o_frame_len(frameLen), .o_good_cnt(goodCnt), .o_bad_cnt(badCnt)
  );

  eth_rx_frame_checker #(.W_CNT(4)) dut4 (
    .i_rx_clk(clk), .i_rx_reset_n(rstN),
    .s_axis_tvalid(sValid), .s_axis_tdata(sData), .s_axis_tkeep(sKeep),
    .s_axis_tlast(sLast), .s_axis_tuser(sUser), .i_clear(clr),
    .o_frame_done(frameDone4), .o_frame_ok(frameOk4), .o_err_flags(errFlags4),
    .o_frame_len(frameLen4), .o_good_cnt(goodCnt4), .o_bad_cnt(badCnt4)
  );

  typedef struct {
    int         due;
    logic [4:0] flags;
    int         len;
    longint     good;
    longint     bad;
    int         good4;
    int         bad4;
  } exp_t;

  typedef struct {
    int         seed;
    int         len;
    int         corruptIdx;
    int         corruptVal;
    bit         user;
    int         keepMode;
    logic [4:0] expFlags;
    int         expLen;
  } vec_t;

  exp_t       expQ[$];
  int         cyc = 0;
  int         nChecks = 0;
  int         nFails = 0;

  bit         mIn;
  int         mSeed, mBeat, mLen;
  bit         mPat, mKeep;
  longint     mGood, mBad;
  int         mGood4, mBad4;
  logic [4:0] lastFlags;
  int         lastLen;
  bit         lastOk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    mIn = 0; mGood = 0; mBad = 0; mGood4 = 0; mBad4 = 0;
    expQ.delete();
    lastFlags = '0; lastLen = 0; lastOk = 0;
  endtask

  task automatic modelClear();
    mGood = 0; mBad = 0; mGood4 = 0; mBad4 = 0;
  endtask

  // Frame-level reference: absolute byte position decides the expected value.
  task automatic modelBeat(input logic [63:0] d, input logic [7:0] k, input bit l,
                           input bit u, input bit c);
    exp_t       e;
    logic [4:0] f;
    bit         legal;
    if (!mIn) begin
      mSeed = int'(d[7:0]); mBeat = 0; mPat = 0; mKeep = 0; mLen = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (k[i]) begin
        mLen++;
        if (d[i*8 +: 8] != 8'(mSeed + mBeat*8 + i)) mPat = 1;
      end
    end
    legal = 0;
    for (int n = 1; n <= 8; n++) if (int'(k) == (1 << n) - 1) legal = 1;
    if (!l && k != 8'hFF) mKeep = 1;
    if (l && !legal) mKeep = 1;
    if (mLen > 65535) mLen = 65535;
    if (l) begin
      f = {u, (mLen > 1514), (mLen < 60), mKeep, mPat};
      if (f == 5'd0) begin
        if (mGood < 64'hFFFF_FFFF) mGood++;
        if (mGood4 < 15) mGood4++;
      end else begin
        if (mBad < 64'hFFFF_FFFF) mBad++;
        if (mBad4 < 15) mBad4++;
      end
      if (c) modelClear();
      e.due = cyc + 2; e.flags = f; e.len = mLen;
      e.good = mGood; e.bad = mBad; e.good4 = mGood4; e.bad4 = mBad4;
      expQ.push_back(e);
      mIn = 0;
    end else begin
      if (c) modelClear();
      mIn = 1;
      mBeat++;
    end
  endtask

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input bit l,
                               input bit u, input bit c);
    @(posedge clk); #1;
    sValid = 1'b1; sData = d; sKeep = k; sLast = l; sUser = u; clr = c;
    modelBeat(d, k, l, u, c);
  endtask

  task automatic driveIdle(input int n, input bit c);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      sValid = 1'b0; sData = {$urandom, $urandom}; sKeep = 8'($urandom);
      sLast = 1'($urandom); sUser = 1'($urandom); clr = c;
      if (c) modelClear();
    end
  endtask

  task automatic waitDrain();
    int t = 0;
    while (expQ.size() > 0 && t < 40) begin
      driveIdle(1, 1'b0);
      t++;
    end
    if (expQ.size() > 0) begin
      checkOutput("drain timeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
    driveIdle(1, 1'b0);
  endtask

  // keepMode 1: first non-last beat has tkeep=0x7F; keepMode 2: last tkeep=0x05.
  task automatic sendFrame(input int seed, input int len, input int corruptIdx,
                           input int corruptVal, input bit user, input int keepMode,
                           input int gapPct, input bit clrLast);
    int          nb, rem, pos;
    bit          isLast;
    logic [63:0] d;
    logic [7:0]  k;
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      if (gapPct > 0 && b > 0 && $urandom_range(99) < gapPct) driveIdle($urandom_range(1, 3), 1'b0);
      for (int i = 0; i < 8; i++) begin
        pos = b*8 + i;
        d[i*8 +: 8] = (pos == corruptIdx) ? 8'(corruptVal) : 8'(seed + pos);
      end
      isLast = (b == nb - 1);
      rem = len - b*8;
      k = isLast ? 8'((1 << rem) - 1) : 8'hFF;
      if (keepMode == 1 && b == 0 && !isLast) k = 8'h7F;
      if (keepMode == 2 && isLast) k = 8'h05;
      applyStimulus(d, k, isLast, isLast ? user : 1'b0, isLast ? clrLast : 1'b0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " done"}, 64'(frameDone), 64'd0);
    checkOutput({tag, " ok"}, 64'(frameOk), 64'd0);
    checkOutput({tag, " flags"}, 64'(errFlags), 64'd0);
    checkOutput({tag, " len"}, 64'(frameLen), 64'd0);
    checkOutput({tag, " good"}, 64'(goodCnt), 64'd0);
    checkOutput({tag, " bad"}, 64'(badCnt), 64'd0);
    checkOutput({tag, " good4"}, 64'(goodCnt4), 64'd0);
    checkOutput({tag, " bad4"}, 64'(badCnt4), 64'd0);
  endtask

  // Scoreboard: every done pulse must match the oldest pending frame at the
  // exact expected cycle; between pulses the verdict outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rstN === 1'b1) begin
      if (frameDone === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected done", 64'(frameDone), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("done timing", 64'(cyc), 64'(e.due));
          checkOutput("flags", 64'(errFlags), 64'(e.flags));
          checkOutput("len", 64'(frameLen), 64'(e.len));
          checkOutput("ok", 64'(frameOk), 64'(e.flags == 5'd0));
          checkOutput("good_cnt", 64'(goodCnt), 64'(e.good));
          checkOutput("bad_cnt", 64'(badCnt), 64'(e.bad));
          checkOutput("done4", 64'(frameDone4), 64'd1);
          checkOutput("good_cnt4", 64'(goodCnt4), 64'(e.good4));
          checkOutput("bad_cnt4", 64'(badCnt4), 64'(e.bad4));
          lastFlags = e.flags; lastLen = e.len; lastOk = (e.flags == 5'd0);
        end
      end else begin
        if (expQ.size() > 0 && expQ[0].due <= cyc) begin
          checkOutput("missing done", 64'(frameDone), 64'd1);
          void'(expQ.pop_front());
        end
        checkOutput("held flags", 64'(errFlags), 64'(lastFlags));
        checkOutput("held len", 64'(frameLen), 64'(lastLen));
        checkOutput("held ok", 64'(frameOk), 64'(lastOk));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        tbl[9];
    int          seed, len, cIdx, kMode;
    bit          cl;
    logic [63:0] d;

    tbl[0] = '{'h10, 64,   -1, 0,    1'b0, 0, 5'b00000, 64};
    tbl[1] = '{'hFC, 61,   20, 'h00, 1'b0, 0, 5'b00001, 61};
    tbl[2] = '{'h00, 64,   -1, 0,    1'b0, 1, 5'b00010, 63};
    tbl[3] = '{'h33, 59,   -1, 0,    1'b0, 0, 5'b00100, 59};
    tbl[4] = '{'h01, 1515, -1, 0,    1'b0, 0, 5'b01000, 1515};
    tbl[5] = '{'h02, 1514, -1, 0,    1'b0, 0, 5'b00000, 1514};
    tbl[6] = '{'h44, 60,   -1, 0,    1'b0, 0, 5'b00000, 60};
    tbl[7] = '{'h55, 8,    -1, 0,    1'b1, 0, 5'b10100, 8};
    tbl[8] = '{'h66, 72,   -1, 0,    1'b0, 2, 5'b00010, 66};

    rstN = 1'b0; sValid = 1'b0; sData = '0; sKeep = '0; sLast = 1'b0; sUser = 1'b0; clr = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #2;
    checkAllZero("reset");
    @(posedge clk); #1;
    rstN = 1'b1;
    driveIdle(2, 1'b0);

    $display("[TB] directed vector table");
    for (int v = 0; v < 9; v++) begin
      sendFrame(tbl[v].seed, tbl[v].len, tbl[v].corruptIdx, tbl[v].corruptVal,
                tbl[v].user, tbl[v].keepMode, 0, 1'b0);
      waitDrain();
      checkOutput($sformatf("vec%0d flags", v), 64'(errFlags), 64'(tbl[v].expFlags));
      checkOutput($sformatf("vec%0d len", v), 64'(frameLen), 64'(tbl[v].expLen));
      checkOutput($sformatf("vec%0d ok", v), 64'(frameOk), 64'(tbl[v].expFlags == 5'd0));
    end
    checkOutput("table good_cnt", 64'(goodCnt), 64'd3);
    checkOutput("table bad_cnt", 64'(badCnt), 64'd6);

    $display("[TB] back-to-back single-beat frames");
    driveIdle(1, 1'b1);
    sendFrame('hA0, 8, -1, 0, 1'b0, 0, 0, 1'b0);
    sendFrame('hB0, 8, -1, 0, 1'b1, 0, 0, 1'b0);
    sendFrame('hC0, 8, -1, 0, 1'b0, 0, 0, 1'b0);
    waitDrain();
    checkOutput("b2b bad_cnt", 64'(badCnt), 64'd3);
    checkOutput("b2b good_cnt", 64'(goodCnt), 64'd0);
    checkOutput("b2b last flags", 64'(errFlags), 64'(5'b00100));

    $display("[TB] gaps inside a frame");
    sendFrame('h3C, 64, -1, 0, 1'b0, 0, 50, 1'b0);
    waitDrain();
    checkOutput("gap ok", 64'(frameOk), 64'd1);
    checkOutput("gap len", 64'(frameLen), 64'd64);

    $display("[TB] clear on the tlast cycle");
    sendFrame('h70, 64, -1, 0, 1'b0, 0, 0, 1'b1);
    waitDrain();
    checkOutput("clear good_cnt", 64'(goodCnt), 64'd0);
    checkOutput("clear bad_cnt", 64'(badCnt), 64'd0);
    checkOutput("clear frame ok", 64'(frameOk), 64'd1);

    $display("[TB] randomized frames");
    for (int r = 0; r < 40; r++) begin
      seed  = int'($urandom_range(0, 255));
      len   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1500, 1530))
                                          : int'($urandom_range(1, 130));
      cIdx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      kMode = int'($urandom_range(0, 5));
      kMode = (kMode > 2) ? 0 : kMode;
      cl    = ($urandom_range(0, 19) == 0);
      if (cl) driveIdle(2, 1'b0);
      sendFrame(seed, len, cIdx, int'($urandom_range(0, 255)), ($urandom_range(0, 6) == 0),
                kMode, ($urandom_range(0, 1) == 1) ? 20 : 0, cl);
      if ($urandom_range(0, 3) == 0) driveIdle($urandom_range(1, 3), 1'b0);
    end
    waitDrain();

    $display("[TB] reset in the middle of a frame");
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'('h20 + b*8 + i);
      applyStimulus(d, 8'hFF, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'('h20 + 24 + i);
    sData = d; sKeep = 8'hFF; sLast = 1'b0;
    rstN = 1'b0;
    modelReset();
    #2;
    checkAllZero("mid-frame reset");
    @(posedge clk); #1;
    sValid = 1'b0;
    rstN = 1'b1;
    for (int b = 3; b < 8; b++) begin
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'('h20 + b*8 + i);
      applyStimulus(d, 8'hFF, (b == 7), 1'b0, 1'b0);
    end
    waitDrain();
    checkOutput("tail flags", 64'(errFlags), 64'(5'b00100));
    checkOutput("tail len", 64'(frameLen), 64'd40);
    checkOutput("tail bad_cnt", 64'(badCnt), 64'd1);

    $display("[TB] counter saturation on the 4-bit build");
    driveIdle(1, 1'b1);
    for (int n = 0; n < 17; n++) sendFrame(n * 7, 64, -1, 0, 1'b0, 0, 0, 1'b0);
    waitDrain();
    checkOutput("sat good_cnt4", 64'(goodCnt4), 64'd15);
    checkOutput("sat good_cnt", 64'(goodCnt), 64'd17);
    checkOutput("sat bad_cnt4", 64'(badCnt4), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
